// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
// Responder side of the start/ready divide handshake; result_o = {remainder, quotient}.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic               r_negq;
  logic               r_negr;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic               w_last;

  always_comb begin
    w_neg1    = signed_div_i & opdata1_i[WIDTH-1];
    w_neg2    = signed_div_i & opdata2_i[WIDTH-1];
    w_abs1    = w_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    w_abs2    = w_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
    // Partial remainder is kept below the divisor, so the shifted value needs one extra bit.
    w_shift   = {r_rem, r_dvd[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_qbit    = ~w_diff[WIDTH];
    w_rem_nx  = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nx  = {r_quo[WIDTH-2:0], w_qbit};
    w_quo_fix = r_negq ? (~w_quo_nx + 1'b1) : w_quo_nx;
    w_rem_fix = r_negr ? (~w_rem_nx + 1'b1) : w_rem_nx;
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= S_BYZERO;
            end else begin
              r_dvd   <= w_abs1;
              r_dvs   <= w_abs2;
              r_negq  <= w_neg1 ^ w_neg2;
              r_negr  <= w_neg1;
              r_cnt   <= '0;
              r_rem   <= '0;
              r_quo   <= '0;
              r_state <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
        S_ON: begin
          if (!start_i || annul_i) begin
            r_state <= S_FREE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= 1'b1;
              r_state  <= S_END;
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            r_ready <= 1'b0;
            r_state <= S_FREE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_FREE;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: driver pushes expected {rem,quo} and latency,
// monitor pops and compares on every rising ready_o.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div_iter #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors;
  int          miscompares;
  int          cyc;
  logic [63:0] last_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer division in 64-bit arithmetic, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest outstanding request.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", {63'd0, ready_o}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", result_o, e.res);
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
      prev = ready_o;
    end
  end

  // Drive a request at the next negedge; the following posedge accepts it.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    exp_t e;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    e.acc = cyc;
    e.res = exp;
    e.lat = (b == 32'd0) ? 2 : 33;
    @(posedge clk);
    #1;
    sb.push_back(e);
    last_res     = exp;
    signed_div_i = $urandom_range(0, 1) == 1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
  endtask

  // Wait for ready, hold in END with annul_i toggled, then release.
  task automatic finish_op();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      chk("ready_timeout", {63'd0, ready_o}, 64'd1);
    end else begin
      annul_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("end_hold_ready", {63'd0, ready_o}, 64'd1);
      chk("end_hold_result", result_o, last_res);
      annul_i = 1'b0;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("release_ready", {63'd0, ready_o}, 64'd0);
      chk("release_result", result_o, last_res);
    end
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    issue(s, a, b, exp);
    finish_op();
  endtask

  // Start 50/5, abort after 10 edges by annul (mode 0) or dropping start (mode 1).
  task automatic abort_test(input int mode);
    logic [63:0] held;
    logic        seen;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    held = result_o;
    repeat (10) @(posedge clk);
    @(negedge clk);
    if (mode == 0) annul_i = 1'b1;
    else           start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | ready_o;
    end
    chk(mode == 0 ? "abort_annul_ready" : "abort_drop_ready", {63'd0, seen}, 64'd0);
    chk("abort_result_kept", result_o, held);
    do_op(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    last_res     = '0;
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    do_op(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    do_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
    do_op(1'b0, 32'h00001234, 32'h00000000, 64'd0);
    do_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF);

    abort_test(0);
    abort_test(1);

    // start and annul together in FREE: nothing accepted until annul drops
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd9;
    opdata2_i    = 32'd4;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    repeat (3) @(negedge clk);
    chk("annul_free_ready", {63'd0, ready_o}, 64'd0);
    do_op(1'b0, 32'd9, 32'd4, 64'h00000001_00000002);

    // reset mid-operation with start held through and after release
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFFFF9C;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midop_reset_ready", {63'd0, ready_o}, 64'd0);
    chk("midop_reset_result", result_o, 64'd0);
    begin
      exp_t e;
      @(negedge clk);
      rst   = 1'b0;
      e.acc = cyc;
      e.res = 64'hFFFFFFFE_FFFFFFF2;
      e.lat = 33;
      @(posedge clk);
      #1;
      sb.push_back(e);
      last_res = e.res;
    end
    finish_op();

    for (int i = 0; i < 60; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 15);
        1: a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      do_op(s, a, b, ref_div(s, a, b));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
